// File: rtl/cpu_run_ctrl.sv
// CPU run controller: holds the CPU in reset, runs it under a clock enable,
// then stops on a flag match, a cycle limit or an abort.
//
// state | meaning
// IDLE  | CPU held in reset, waiting for start
// HOLD  | CPU reset asserted for RST_CYCLES cycles
// RUN   | CPU enabled, cycles counted, flags monitored
// DONE  | run finished, results held until next start
module cpu_run_ctrl #(
  parameter int CNT_W         = 16,
  parameter int NFLAGS        = 2,
  parameter int RST_CYCLES    = 2,
  parameter int STOP_ON_MATCH = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  max_cycles,
  input  logic [NFLAGS-1:0] stop_mask,
  input  logic [NFLAGS-1:0] stop_value,
  input  logic [NFLAGS-1:0] flags,
  output logic              cpu_rst_n,
  output logic              cpu_en,
  output logic              running,
  output logic              done,
  output logic              timeout,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [NFLAGS-1:0] flag_sticky
);

  typedef enum logic [1:0] {IDLE, HOLD, RUN, DONE} state_t;

  localparam logic [3:0]       HOLD_LOAD = 4'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic              armed_q;
  logic [3:0]        hold_q;
  logic [CNT_W-1:0]  max_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [NFLAGS-1:0] mask_q;
  logic [NFLAGS-1:0] value_q;
  logic [NFLAGS-1:0] sticky_q;
  logic              timeout_q;

  logic              start_ok;
  logic              match;
  logic              limit_hit;
  logic [CNT_W-1:0]  cnt_plus;
  logic [CNT_W-1:0]  cnt_sat;

  // armed_q keeps the first edge after reset release from accepting start
  assign start_ok  = start && armed_q && (state_q == IDLE || state_q == DONE);
  assign match     = (STOP_ON_MATCH != 0) && (mask_q != '0) &&
                     (((flags ^ value_q) & mask_q) == '0);
  assign cnt_plus  = cnt_q + CNT_ONE;
  assign cnt_sat   = (cnt_q == '1) ? cnt_q : cnt_plus;
  assign limit_hit = (max_q != '0) && (cnt_plus == max_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start_ok) state_d = HOLD;
      HOLD: begin
        if (abort)              state_d = DONE;
        else if (hold_q == '0)  state_d = RUN;
      end
      RUN: begin
        if (abort || match || limit_hit) state_d = DONE;
      end
      DONE: if (start_ok) state_d = HOLD;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      armed_q   <= 1'b0;
      hold_q    <= '0;
      max_q     <= '0;
      cnt_q     <= '0;
      mask_q    <= '0;
      value_q   <= '0;
      sticky_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      armed_q <= 1'b1;
      state_q <= state_d;
      if (start_ok) begin
        max_q     <= max_cycles;
        mask_q    <= stop_mask;
        value_q   <= stop_value;
        cnt_q     <= '0;
        sticky_q  <= '0;
        timeout_q <= 1'b0;
        hold_q    <= HOLD_LOAD;
      end else begin
        case (state_q)
          HOLD: begin
            if (!abort && hold_q != '0) hold_q <= hold_q - 4'd1;
          end
          RUN: begin
            sticky_q <= sticky_q | flags;
            // an aborted cycle is not counted and never reports a timeout
            if (!abort) begin
              cnt_q     <= cnt_sat;
              timeout_q <= limit_hit && !match;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign cpu_rst_n   = (state_q == RUN) || (state_q == DONE);
  assign cpu_en      = (state_q == RUN);
  assign running     = (state_q == RUN);
  assign done        = (state_q == DONE);
  assign timeout     = timeout_q;
  assign cycle_cnt   = cnt_q;
  assign flag_sticky = sticky_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: directed and random runs checked against a
// run-level reference model of the stop rules.
module tb_cpu_run_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort;
  logic [15:0] max_cycles;
  logic [1:0]  stop_mask, stop_value, flags;
  logic        cpu_rst_n, cpu_en, running, done, timeout;
  logic [15:0] cycle_cnt;
  logic [1:0]  flag_sticky;

  logic        start4, abort4;
  logic [3:0]  max4;
  logic        cpu_rst_n4, cpu_en4, running4, done4, timeout4;
  logic [3:0]  cycle_cnt4;
  logic [1:0]  flag_sticky4;

  int n_chk  = 0;
  int n_pass = 0;

  logic [1:0] fseq [0:79];

  always #5 clk = ~clk;

  cpu_run_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .max_cycles(max_cycles), .stop_mask(stop_mask), .stop_value(stop_value),
    .flags(flags), .cpu_rst_n(cpu_rst_n), .cpu_en(cpu_en), .running(running),
    .done(done), .timeout(timeout), .cycle_cnt(cycle_cnt),
    .flag_sticky(flag_sticky)
  );

  cpu_run_ctrl #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .abort(abort4),
    .max_cycles(max4), .stop_mask(stop_mask), .stop_value(stop_value),
    .flags(flags), .cpu_rst_n(cpu_rst_n4), .cpu_en(cpu_en4),
    .running(running4), .done(done4), .timeout(timeout4),
    .cycle_cnt(cycle_cnt4), .flag_sticky(flag_sticky4)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp_v);
    n_chk++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
  endtask

  // Run outcome straight from the stop rules: walk the enabled cycles until
  // abort, match or limit ends the run.
  function automatic void model(input int maxc, input logic [1:0] m,
                                input logic [1:0] v, input int ab,
                                output int cnt, output bit to,
                                output logic [1:0] st);
    st = '0; cnt = 0; to = 1'b0;
    for (int k = 1; k < 80; k++) begin
      st |= fseq[k];
      if (ab != 0 && ab == k - 1) begin cnt = k - 1; return; end
      cnt = k;
      if (m != 0 && ((fseq[k] & m) == (v & m))) return;
      if (maxc != 0 && k == maxc) begin to = 1'b1; return; end
    end
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cpu_rst_n"}, cpu_rst_n, 0);
    chk({tag, "_cpu_en"},    cpu_en, 0);
    chk({tag, "_running"},   running, 0);
    chk({tag, "_done"},      done, 0);
    chk({tag, "_timeout"},   timeout, 0);
    chk({tag, "_cycle_cnt"}, cycle_cnt, 0);
    chk({tag, "_sticky"},    flag_sticky, 0);
  endtask

  task automatic start_and_hold(input string tag, input int maxc,
                                input logic [1:0] m, input logic [1:0] v);
    int hold_n;
    max_cycles = 16'(maxc); stop_mask = m; stop_value = v; start = 1'b1;
    @(negedge clk);
    start = 1'b0; max_cycles = '0; stop_mask = '0; stop_value = '0;
    hold_n = 0;
    while (!running && hold_n < 20) begin
      chk({tag, "_hold_rst"}, {cpu_rst_n, cpu_en}, 2'b00);
      hold_n++;
      @(negedge clk);
    end
    chk({tag, "_hold_len"}, hold_n, 2);
  endtask

  task automatic run_one(input string tag, input int maxc, input logic [1:0] m,
                         input logic [1:0] v, input int ab);
    int k;
    int e_cnt;
    bit e_to;
    logic [1:0] e_st;
    model(maxc, m, v, ab, e_cnt, e_to, e_st);
    start_and_hold(tag, maxc, m, v);
    k = 1;
    while (running && k < 80) begin
      if (k == 1) chk({tag, "_run_en"}, {cpu_rst_n, cpu_en}, 2'b11);
      chk({tag, "_cnt_run"}, cycle_cnt, k - 1);
      flags = fseq[k];
      abort = (ab != 0 && ab == k - 1);
      @(negedge clk);
      k++;
    end
    abort = 1'b0;
    flags = '0;
    chk({tag, "_ended"}, (k < 80), 1);
    chk({tag, "_done"},      done, 1);
    chk({tag, "_timeout"},   timeout, e_to);
    chk({tag, "_cycle_cnt"}, cycle_cnt, e_cnt);
    chk({tag, "_sticky"},    flag_sticky, e_st);
    chk({tag, "_cpu_off"},   {cpu_rst_n, cpu_en}, 2'b10);
    @(negedge clk);
    chk({tag, "_hold_cnt"},  cycle_cnt, e_cnt);
    chk({tag, "_hold_done"}, done, 1);
  endtask

  initial begin
    int n;
    int maxc;
    logic [1:0] m, v;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; flags = '0;
    max_cycles = '0; stop_mask = '0; stop_value = '0;
    start4 = 1'b0; abort4 = 1'b0; max4 = '0;
    #1;
    check_reset_outputs("por");
    chk("por_dut4", {cpu_rst_n4, cpu_en4, running4, done4, timeout4, cycle_cnt4}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // limit only
    for (int k = 0; k < 80; k++) fseq[k] = 2'($urandom);
    run_one("limit44", 44, 2'b00, 2'b00, 0);

    // equal flag match at RUN cycle 10
    for (int k = 0; k < 80; k++) fseq[k] = {1'(k >= 10), 1'($urandom)};
    run_one("match10", 0, 2'b10, 2'b10, 0);

    // match and limit on the same cycle
    run_one("match_lim", 10, 2'b10, 2'b10, 0);

    // abort after five counted cycles
    for (int k = 0; k < 80; k++) fseq[k] = 2'($urandom);
    run_one("abort5", 0, 2'b00, 2'b00, 5);

    // random runs
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 80; k++)
        fseq[k] = {1'($urandom_range(7) == 0), 1'($urandom_range(7) == 0)};
      maxc = int'($urandom_range(60, 1));
      m = 2'($urandom); v = 2'($urandom);
      run_one("rand", maxc, m, v, ($urandom_range(3) == 0) ? int'($urandom_range(20, 1)) : 0);
    end

    // asynchronous reset in the middle of a run
    for (int k = 0; k < 80; k++) fseq[k] = 2'b11;
    start_and_hold("midrst", 0, 2'b00, 2'b00);
    n = 0;
    while (running && n < 6) begin flags = fseq[n]; @(negedge clk); n++; end
    chk("midrst_cnt_pre", cycle_cnt, 6);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1; start = 1'b1; max_cycles = 16'd3;
    @(negedge clk);
    start = 1'b0;
    chk("rel_start_ignored", {running, done, cpu_rst_n}, 3'b000);
    @(negedge clk);
    chk("rel_still_idle", {running, done, cpu_rst_n}, 3'b000);
    for (int k = 0; k < 80; k++) fseq[k] = 2'($urandom);
    run_one("after_rst", 12, 2'b00, 2'b00, 0);

    // 4-bit counter saturates with no limit
    stop_mask = '0; stop_value = '0; max4 = 4'd0; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    n = 0;
    while (!running4 && n < 20) begin @(negedge clk); n++; end
    chk("sat_hold_len", n, 2);
    n = 0;
    while (running4 && n < 20) begin @(negedge clk); n++; end
    chk("sat_ran20", n, 20);
    chk("sat_cnt_run", cycle_cnt4, (20 > 15) ? 15 : 20);
    abort4 = 1'b1;
    @(negedge clk);
    abort4 = 1'b0;
    chk("sat_cnt", cycle_cnt4, 4'hF);
    chk("sat_done", {done4, timeout4, cpu_en4, cpu_rst_n4}, 4'b1001);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cpu_run_ctrl.md
CPU_RUN_CTRL -- requirements
Module: cpu_run_ctrl

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, meaning the width of the cycle counter and of the limit input.
REQ-002 The block SHALL have parameter NFLAGS, default 2, meaning the number of CPU status flags monitored (bit0 = res_zero, bit1 = equal).
REQ-003 The block SHALL have parameter RST_CYCLES, default 2, meaning the number of cycles the CPU is held in reset before running (range 1..15).
REQ-004 The block SHALL have parameter STOP_ON_MATCH, default 1, meaning flag-match stop is enabled (1) or the block runs to the cycle limit only (0).
REQ-005 The block SHALL run on one clock, clk, with reset rst_n asynchronous and active-low.
REQ-006 The block SHALL have ports as follows:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse that begins a run
- abort  in  1  ends a run immediately
- max_cycles  in  CNT_W  run length limit, sampled on start
- stop_mask  in  NFLAGS  flags that take part in the match stop, sampled on start
- stop_value  in  NFLAGS  required flag values for a match, sampled on start
- flags  in  NFLAGS  CPU status flags, sampled every RUN cycle
- cpu_rst_n  out  1  active-low reset to the CPU
- cpu_en  out  1  clock enable to the CPU
- running  out  1  high in RUN
- done  out  1  sticky high in DONE
- timeout  out  1  run ended on the cycle limit
- cycle_cnt  out  CNT_W  number of enabled CPU cycles
- flag_sticky  out  NFLAGS  OR of each flag over the run

Function
REQ-007 The block SHALL implement the states IDLE, HOLD, RUN and DONE.
REQ-008 From IDLE, start SHALL move the block to HOLD on the next edge, latch max_cycles, stop_mask and stop_value, and clear cycle_cnt, flag_sticky, timeout and done.
REQ-009 The block SHALL stay in HOLD for exactly RST_CYCLES cycles with cpu_rst_n=0 and cpu_en=0, then move to RUN.
REQ-010 In RUN the block SHALL drive cpu_rst_n=1, cpu_en=1 and running=1, and SHALL increment cycle_cnt by 1 per cycle.
REQ-011 In RUN, flag_sticky SHALL be updated each cycle as flag_sticky OR flags, with the new value visible on the next cycle.
REQ-012 With STOP_ON_MATCH=1 and stop_mask nonzero, a RUN cycle where (flags AND stop_mask) == (stop_value AND stop_mask) SHALL end the run: DONE on the next edge, timeout=0, and that cycle is counted.
REQ-013 A RUN cycle where cycle_cnt+1 == max_cycles SHALL end the run: DONE on the next edge, with timeout=1 unless a match stop occurs in the same cycle; a match stop has priority, giving timeout=0.
REQ-014 max_cycles=0 SHALL mean no limit; in that case cycle_cnt SHALL saturate at all-ones and not wrap.
REQ-015 abort in HOLD or RUN SHALL move the block to DONE on the next edge with timeout=0 and cycle_cnt frozen; abort SHALL take priority over match and limit.
REQ-016 In DONE the block SHALL drive done=1, cpu_en=0 and cpu_rst_n=1, and SHALL hold cycle_cnt, flag_sticky and timeout.
REQ-017 start in DONE SHALL begin a new run exactly as from IDLE; start in HOLD or RUN SHALL be ignored.
REQ-018 In IDLE the block SHALL drive cpu_rst_n=0 and cpu_en=0.
REQ-019 All outputs SHALL be registered or decoded from the state register only, with no combinational path from any input to any output.

Reset
REQ-020 When rst_n=0, the block SHALL immediately enter IDLE and drive cpu_rst_n=0, cpu_en=0, running=0, done=0, timeout=0, cycle_cnt=0 and flag_sticky=0, including when reset arrives in the middle of a run.
REQ-021 After rst_n is released, the block SHALL ignore start in the first clock edge.

Verification
REQ-022 The bench SHALL cover: defaults, max_cycles=44, stop_mask=0, start -> 2 HOLD cycles, then 44 RUN cycles, then done=1, timeout=1, cycle_cnt=44.
REQ-023 The bench SHALL cover: stop_mask=2'b10, stop_value=2'b10, equal rising at RUN cycle 10 -> DONE next edge, cycle_cnt=10, timeout=0, flag_sticky[1]=1.
REQ-024 The bench SHALL cover: the match and the limit falling in the same cycle (max_cycles=10) -> timeout=0, cycle_cnt=10.
REQ-025 The bench SHALL cover: abort at RUN cycle 5 -> DONE, cycle_cnt=5, timeout=0, cpu_en=0 from the next cycle.
REQ-026 The bench SHALL cover: rst_n low at RUN cycle 7 -> all outputs at reset values without waiting for a clock edge; a new start after release runs normally.
REQ-027 The bench SHALL cover: CNT_W=4, max_cycles=0, run 20 cycles, then abort -> cycle_cnt=4'hF (saturated).
